cpld_z80_cycle_decoder: RTL and testbench

- Front-end stage of the CPC RAM-expansion CPLD. Sits directly upstream of the RAM bank-mapping logic.
- Samples Z80 bus strobes on clk and classifies each machine cycle as memory read, memory write, refresh, IO read, IO write or interrupt acknowledge.
- Captures A15/A14 at cycle start and produces registered cycle qualifiers for the mapper.
- Snoops IO writes to 0x7FXX to produce the bank-configuration register and its write strobe.

---
 rtl/cpld_z80_cycle_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_cpld_z80_cycle_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld_z80_cycle_decoder.sv
// Z80 machine-cycle classifier for the CPC RAM-expansion CPLD: qualifies each bus cycle
// for the bank mapper and snoops 0x7FXX writes. Build with CYCLE_COUNT_EN to add mwr_count.
module cpld_z80_cycle_decoder #(
    parameter int MAX_T = 15,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        mreq_b,
    input  logic        iorq_b,
    input  logic        rd_b,
    input  logic        wr_b,
    input  logic        rfsh_b,
    input  logic        m1_b,
    input  logic        ready,
    input  logic        adr15,
    input  logic        adr14,
    input  logic [7:0]  data,
    output logic [1:0]  adr_hi_q,
    output logic        mrd_cyc,
    output logic        mwr_cyc,
    output logic        iowr_stb,
    output logic        cfg_wr_stb,
    output logic [5:0]  cfg_q,
    output logic [2:0]  cyc_state,
    output logic        bus_err,
    output logic        bus_timeout,
    output logic [15:0] mwr_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MEM  = 3'd1;
    localparam logic [2:0] ST_RFSH = 3'd2;
    localparam logic [2:0] ST_IO   = 3'd3;
    localparam logic [2:0] ST_INTA = 3'd4;
    localparam logic [2:0] ST_END  = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_T);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       adr_hi_reg, adr_hi_next;
    logic             mrd_reg, mrd_next;
    logic             mwr_reg, mwr_next;
    logic             iowr_stb_reg, iowr_stb_next;
    logic             cfg_wr_stb_reg, cfg_wr_stb_next;
    logic [5:0]       cfg_reg, cfg_next;
    logic             bus_err_reg, bus_err_next;
    logic             bus_timeout_reg, bus_timeout_next;
    logic             io_done_reg, io_done_next;
    logic             rst_exit_reg, rst_exit_next;

    logic timeout_hit;
    logic cnt_inc_ok;

    // The counter holds at MAX_T; one more ready clk is the overrun.
    assign timeout_hit = ready && (cnt_reg == CNT_MAX);
    assign cnt_inc_ok  = ready && (cnt_reg != CNT_MAX);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        adr_hi_next      = adr_hi_reg;
        mrd_next         = mrd_reg;
        mwr_next         = mwr_reg;
        iowr_stb_next    = 1'b0;
        cfg_wr_stb_next  = 1'b0;
        cfg_next         = cfg_reg;
        bus_err_next     = bus_err_reg;
        bus_timeout_next = bus_timeout_reg;
        io_done_next     = io_done_reg;
        rst_exit_next    = rst_exit_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                io_done_next = 1'b0;
                mrd_next     = 1'b0;
                mwr_next     = 1'b0;
                // First clk after reset: any half-seen cycle is parked in END.
                if (rst_exit_reg) begin
                    rst_exit_next = 1'b0;
                    state_next    = ST_END;
                end else if (!mreq_b && !iorq_b) begin
                    bus_err_next = 1'b1;
                    state_next   = ST_END;
                end else if (!mreq_b && rfsh_b) begin
                    adr_hi_next = {adr15, adr14};
                    state_next  = ST_MEM;
                end else if (!mreq_b) begin
                    state_next = ST_RFSH;
                end else if (!iorq_b && m1_b) begin
                    adr_hi_next = {adr15, adr14};
                    state_next  = ST_IO;
                end else if (!iorq_b) begin
                    state_next = ST_INTA;
                end
            end

            ST_MEM: begin
                if (mreq_b) begin
                    mrd_next   = 1'b0;
                    mwr_next   = 1'b0;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    bus_timeout_next = 1'b1;
                    mrd_next         = 1'b0;
                    mwr_next         = 1'b0;
                    state_next       = ST_END;
                end else begin
                    if (cnt_inc_ok) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (!rd_b && !wr_b) begin
                        bus_err_next = 1'b1;
                    end else if (!rd_b && !mwr_reg) begin
                        mrd_next = 1'b1;
                    end else if (!wr_b && !mrd_reg) begin
                        mwr_next = 1'b1;
                    end
                end
            end

            ST_IO: begin
                if (iorq_b) begin
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    bus_timeout_next = 1'b1;
                    state_next       = ST_END;
                end else begin
                    if (cnt_inc_ok) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    // Gate-array port 0x7FXX decodes on A15 low; 11 in data[7:6] selects RAM config.
                    if (!wr_b && !io_done_reg) begin
                        io_done_next  = 1'b1;
                        iowr_stb_next = 1'b1;
                        if (!adr_hi_reg[1] && (data[7:6] == 2'b11)) begin
                            cfg_next        = data[5:0];
                            cfg_wr_stb_next = 1'b1;
                        end
                    end
                end
            end

            ST_RFSH: begin
                if (mreq_b) begin
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    bus_timeout_next = 1'b1;
                    state_next       = ST_END;
                end else if (cnt_inc_ok) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_INTA: begin
                if (iorq_b) begin
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    bus_timeout_next = 1'b1;
                    state_next       = ST_END;
                end else if (cnt_inc_ok) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_END: begin
                if (mreq_b && iorq_b) begin
                    state_next = ST_IDLE;
                end else if (cnt_inc_ok) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_END;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            adr_hi_reg      <= 2'b00;
            mrd_reg         <= 1'b0;
            mwr_reg         <= 1'b0;
            iowr_stb_reg    <= 1'b0;
            cfg_wr_stb_reg  <= 1'b0;
            cfg_reg         <= 6'b000000;
            bus_err_reg     <= 1'b0;
            bus_timeout_reg <= 1'b0;
            io_done_reg     <= 1'b0;
            rst_exit_reg    <= 1'b1;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            adr_hi_reg      <= adr_hi_next;
            mrd_reg         <= mrd_next;
            mwr_reg         <= mwr_next;
            iowr_stb_reg    <= iowr_stb_next;
            cfg_wr_stb_reg  <= cfg_wr_stb_next;
            cfg_reg         <= cfg_next;
            bus_err_reg     <= bus_err_next;
            bus_timeout_reg <= bus_timeout_next;
            io_done_reg     <= io_done_next;
            rst_exit_reg    <= rst_exit_next;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] mwr_count_reg;
    logic        mwr_first;

    assign mwr_first = mwr_next && !mwr_reg;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mwr_count_reg <= 16'h0000;
        end else if (mwr_first && (mwr_count_reg != 16'hFFFF)) begin
            mwr_count_reg <= mwr_count_reg + 16'h0001;
        end
    end

    assign mwr_count = mwr_count_reg;
`else
    assign mwr_count = 16'h0000;
`endif

    assign adr_hi_q    = adr_hi_reg;
    assign mrd_cyc     = mrd_reg;
    assign mwr_cyc     = mwr_reg;
    assign iowr_stb    = iowr_stb_reg;
    assign cfg_wr_stb  = cfg_wr_stb_reg;
    assign cfg_q       = cfg_reg;
    assign cyc_state   = state_reg;
    assign bus_err     = bus_err_reg;
    assign bus_timeout = bus_timeout_reg;

endmodule

// File: tb/tb_cpld_z80_cycle_decoder.sv
// Scoreboarded bench for cpld_z80_cycle_decoder: stimulus queues expected qualifier events,
// a negedge monitor pops and checks them as strobes/qualifiers appear.
module tb_cpld_z80_cycle_decoder;

    logic        clk;
    logic        reset_b;
    logic        mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15, adr14;
    logic [7:0]  data;
    logic [1:0]  adr_hi_q;
    logic        mrd_cyc, mwr_cyc, iowr_stb, cfg_wr_stb, bus_err, bus_timeout;
    logic [5:0]  cfg_q;
    logic [2:0]  cyc_state;
    logic [15:0] mwr_count;

    cpld_z80_cycle_decoder #(.MAX_T(15), .CNT_W(4)) dut (
        .clk(clk), .reset_b(reset_b),
        .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b),
        .rfsh_b(rfsh_b), .m1_b(m1_b), .ready(ready),
        .adr15(adr15), .adr14(adr14), .data(data),
        .adr_hi_q(adr_hi_q), .mrd_cyc(mrd_cyc), .mwr_cyc(mwr_cyc),
        .iowr_stb(iowr_stb), .cfg_wr_stb(cfg_wr_stb), .cfg_q(cfg_q),
        .cyc_state(cyc_state), .bus_err(bus_err), .bus_timeout(bus_timeout),
        .mwr_count(mwr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int EV_IO = 1, EV_MW = 2, EV_MR = 3, EV_RF = 4;

    typedef struct {
        int          kind;
        logic [1:0]  adr;
        logic        cfg_stb;
        logic [5:0]  cfg;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [5:0]  cfg_model = 6'd0;
    logic [15:0] mwr_model = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_ev(input int kind, input logic [1:0] adr, input logic stb,
                           input logic [5:0] cfg, input logic [15:0] cnt);
        exp_t e;
        e.kind = kind; e.adr = adr; e.cfg_stb = stb; e.cfg = cfg; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected entry for every qualifier event the DUT raises.
    logic       prev_mwr = 1'b0, prev_mrd = 1'b0;
    logic [2:0] prev_state = 3'd0;

    task automatic pop_and_check(input int kind, input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_event"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_kind"}, kind, e.kind);
            chk({tag, "_adr_hi"}, {30'd0, adr_hi_q}, {30'd0, e.adr});
            if (kind == EV_IO) begin
                chk({tag, "_cfg_wr_stb"}, {31'd0, cfg_wr_stb}, {31'd0, e.cfg_stb});
                chk({tag, "_cfg_q"}, {26'd0, cfg_q}, {26'd0, e.cfg});
            end
            if (kind == EV_MW) begin
                chk({tag, "_mrd_clear"}, {31'd0, mrd_cyc}, 32'd0);
                chk({tag, "_mwr_count"}, {16'd0, mwr_count}, {16'd0, e.cnt});
            end
            if (kind == EV_RF) begin
                chk({tag, "_no_qual"}, {30'd0, mrd_cyc, mwr_cyc}, 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_b) begin
            if (iowr_stb) pop_and_check(EV_IO, "io_wr");
            if (cfg_wr_stb && !iowr_stb) chk("cfg_stb_without_iowr", 32'd1, 32'd0);
            if (mwr_cyc && !prev_mwr) pop_and_check(EV_MW, "mem_wr");
            if (mrd_cyc && !prev_mrd) pop_and_check(EV_MR, "mem_rd");
            if (cyc_state == 3'd2 && prev_state != 3'd2) pop_and_check(EV_RF, "rfsh");
        end
        prev_mwr   = mwr_cyc;
        prev_mrd   = mrd_cyc;
        prev_state = cyc_state;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic io_write(input logic a15, input logic [7:0] d);
        logic stb;
        stb = !a15 && (d[7:6] == 2'b11);
        if (stb) cfg_model = d[5:0];
        push_ev(EV_IO, {a15, 1'b0}, stb, cfg_model, 16'd0);
        adr15 = a15; adr14 = 1'b0; data = d; m1_b = 1'b1; iorq_b = 1'b0;
        cyc(1);
        wr_b = 1'b0;
        cyc(3);
        iorq_b = 1'b1; wr_b = 1'b1;
        cyc(1);
        chk("io_state_idle", {29'd0, cyc_state}, 32'd0);
    endtask

    task automatic mem_write(input logic a15, input logic a14, input int waits);
`ifdef CYCLE_COUNT_EN
        mwr_model = mwr_model + 16'd1;
`endif
        adr15 = a15; adr14 = a14; rfsh_b = 1'b1; m1_b = 1'b1; mreq_b = 1'b0;
        cyc(1);
        push_ev(EV_MW, {a15, a14}, 1'b0, 6'd0, mwr_model);
        wr_b = 1'b0; ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            cyc(1);
            chk("mw_wait_mwr_cyc", {31'd0, mwr_cyc}, 32'd1);
        end
        ready = 1'b1;
        cyc(1);
        chk("mw_mwr_cyc", {31'd0, mwr_cyc}, 32'd1);
        chk("mw_mrd_cyc", {31'd0, mrd_cyc}, 32'd0);
        mreq_b = 1'b1; wr_b = 1'b1;
        cyc(1);
        chk("mw_end_mwr_clear", {31'd0, mwr_cyc}, 32'd0);
        chk("mw_end_state", {29'd0, cyc_state}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0;
        mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
        rfsh_b = 1'b1; m1_b = 1'b1; ready = 1'b1;
        adr15 = 1'b0; adr14 = 1'b0; data = 8'h00;
        cyc(3);
        chk("rst_state", {29'd0, cyc_state}, 32'd0);
        chk("rst_cfg_q", {26'd0, cfg_q}, 32'd0);
        chk("rst_flags", {25'd0, adr_hi_q, mrd_cyc, mwr_cyc, iowr_stb, cfg_wr_stb, bus_err}, 32'd0);
        chk("rst_timeout_count", {15'd0, bus_timeout, mwr_count}, 32'd0);
        reset_b = 1'b1;
        cyc(1);
        chk("rst_exit_end", {29'd0, cyc_state}, 32'd5);
        cyc(1);
        chk("rst_exit_idle", {29'd0, cyc_state}, 32'd0);

        // Config write, then two rejected writes back to back.
        io_write(1'b0, 8'hC2);
        io_write(1'b1, 8'hC5);
        io_write(1'b0, 8'h85);
        chk("cfg_unchanged", {26'd0, cfg_q}, {26'd0, cfg_model});

        mem_write(1'b1, 1'b1, 2);
        mem_write(1'b0, 1'b1, 0);

        // Opcode fetch from 0x8xxx, then refresh with a different address.
        adr15 = 1'b1; adr14 = 1'b0; m1_b = 1'b0; mreq_b = 1'b0; rd_b = 1'b0;
        push_ev(EV_MR, 2'b10, 1'b0, 6'd0, 16'd0);
        cyc(3);
        mreq_b = 1'b1; rd_b = 1'b1; m1_b = 1'b1; rfsh_b = 1'b0; adr15 = 1'b0;
        cyc(1);
        mreq_b = 1'b0;
        push_ev(EV_RF, 2'b10, 1'b0, 6'd0, 16'd0);
        cyc(1);
        chk("rfsh_state", {29'd0, cyc_state}, 32'd2);
        cyc(1);
        mreq_b = 1'b1; rfsh_b = 1'b1;
        cyc(1);
        chk("rfsh_adr_kept", {30'd0, adr_hi_q}, 32'd2);
        chk("rfsh_idle", {29'd0, cyc_state}, 32'd0);

        // MREQ and IORQ together.
        mreq_b = 1'b0; iorq_b = 1'b0;
        cyc(1);
        chk("buserr_set", {31'd0, bus_err}, 32'd1);
        chk("buserr_state_end", {29'd0, cyc_state}, 32'd5);
        cyc(2);
        chk("buserr_hold_end", {29'd0, cyc_state}, 32'd5);
        mreq_b = 1'b1; iorq_b = 1'b1;
        cyc(1);
        chk("buserr_idle", {29'd0, cyc_state}, 32'd0);
        cyc(3);
        chk("buserr_sticky", {31'd0, bus_err}, 32'd1);

        // Wait states do not count toward the timeout.
        mreq_b = 1'b0; ready = 1'b0;
        cyc(41);
        chk("wait_no_timeout", {31'd0, bus_timeout}, 32'd0);
        chk("wait_state_mem", {29'd0, cyc_state}, 32'd1);
        mreq_b = 1'b1; ready = 1'b1;
        cyc(1);

        // 15 ready clks in MEM are allowed; the 16th overruns.
        mreq_b = 1'b0;
        cyc(16);
        chk("to_not_yet", {31'd0, bus_timeout}, 32'd0);
        chk("to_still_mem", {29'd0, cyc_state}, 32'd1);
        cyc(1);
        chk("to_set", {31'd0, bus_timeout}, 32'd1);
        chk("to_state_end", {29'd0, cyc_state}, 32'd5);
        mreq_b = 1'b1;
        cyc(1);
        chk("to_idle", {29'd0, cyc_state}, 32'd0);
        cyc(2);
        chk("to_sticky", {31'd0, bus_timeout}, 32'd1);

        // Reset in the middle of an IO write.
        adr15 = 1'b0; data = 8'hC7; iorq_b = 1'b0;
        cyc(1);
        wr_b = 1'b0;
        reset_b = 1'b0;
        #1;
        cfg_model = 6'd0;
        mwr_model = 16'd0;
        chk("midrst_cfg_q", {26'd0, cfg_q}, 32'd0);
        chk("midrst_state", {29'd0, cyc_state}, 32'd0);
        chk("midrst_sticky_clear", {30'd0, bus_err, bus_timeout}, 32'd0);
        cyc(2);
        reset_b = 1'b1;
        cyc(1);
        chk("midrst_exit_end", {29'd0, cyc_state}, 32'd5);
        cyc(3);
        chk("midrst_ignored", {29'd0, cyc_state}, 32'd5);
        iorq_b = 1'b1; wr_b = 1'b1;
        cyc(1);
        chk("midrst_idle", {29'd0, cyc_state}, 32'd0);
        io_write(1'b0, 8'hFF);
        mem_write(1'b0, 1'b0, 1);

        cyc(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
